// File: rtl/bram_capture_buffer.sv
// Trigger-based multi-channel capture memory: circular pre-trigger history plus a
// post-trigger window in one inferred simple dual-port RAM, read back oldest-first.
module bram_capture_buffer #(
  parameter int RAM_WIDTH = 8,
  parameter int NUM_CH    = 2,
  parameter int RAM_DEPTH = 1024,
  parameter int PRE_TRIG  = 256,
  parameter int OUT_REG   = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sample_valid,
  input  logic [NUM_CH*RAM_WIDTH-1:0]   sample_in,
  input  logic                          arm,
  input  logic                          trigger,
  input  logic                          rd_enable,
  input  logic [$clog2(RAM_DEPTH)-1:0]  rd_addr,
  output logic [NUM_CH*RAM_WIDTH-1:0]   rd_data,
  output logic                          rd_valid,
  output logic                          busy,
  output logic                          triggered,
  output logic                          done,
  output logic [2:0]                    dbg_state
);

  localparam int W  = NUM_CH * RAM_WIDTH;
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(RAM_DEPTH + 1);

  localparam logic [PW-1:0] PTR_LAST  = PW'(RAM_DEPTH - 1);
  localparam logic [PW-1:0] PRE_P     = PW'(PRE_TRIG);
  localparam logic [PW-1:0] PRE_COMP  = PW'(RAM_DEPTH - PRE_TRIG);
  localparam logic [PW-1:0] FILL_LAST = PW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [PW-1:0] POST_LAST = PW'(RAM_DEPTH - PRE_TRIG - 1);
  localparam logic [PW:0]   DEPTH_X   = (PW+1)'(RAM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   wr_ptr, fill_cnt, post_cnt, trig_ptr, start_ptr;
  logic            wr_en, trig_hit;
  logic [W-1:0]    mem [0:RAM_DEPTH-1];

  assign dbg_state = state;

  // Oldest retained sample sits PRE_TRIG entries behind the trigger sample.
  assign start_ptr = (trig_ptr >= PRE_P) ? (trig_ptr - PRE_P) : (trig_ptr + PRE_COMP);

  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    trig_hit = 1'b0;
    if (arm) begin
      state_n = (PRE_TRIG > 0) ? S_FILL : S_WAIT_TRIG;
    end else begin
      case (state)
        S_FILL: if (sample_valid) begin
          wr_en = 1'b1;
          if (fill_cnt == FILL_LAST) state_n = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: if (sample_valid) begin
          wr_en = 1'b1;
          if (trigger) begin
            trig_hit = 1'b1;
            state_n  = (RAM_DEPTH - PRE_TRIG == 1) ? S_DONE : S_POST;
          end
        end
        S_POST: if (sample_valid) begin
          wr_en = 1'b1;
          if (post_cnt == POST_LAST) state_n = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      trig_ptr  <= '0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= (state_n == S_FILL) || (state_n == S_WAIT_TRIG) || (state_n == S_POST);
      triggered <= (state_n == S_POST) || (state_n == S_DONE);
      done      <= (state_n == S_DONE);
      if (arm) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
        post_cnt <= '0;
      end else if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
        if (state == S_FILL) fill_cnt <= fill_cnt + PW'(1);
        if (state == S_POST) post_cnt <= post_cnt + PW'(1);
        if (trig_hit) begin
          trig_ptr <= wr_ptr;
          post_cnt <= PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[AW'(wr_ptr)] <= sample_in;
  end

  // Read side: logical index rotated by start_ptr, explicit modulo for any depth.
  logic [PW:0]   rd_sum;
  logic [AW-1:0] rd_phys;
  logic          rd_ok;

  assign rd_sum  = {1'b0, start_ptr} + {{(PW+1-AW){1'b0}}, rd_addr};
  assign rd_phys = (rd_sum >= DEPTH_X) ? AW'(rd_sum - DEPTH_X) : AW'(rd_sum);
  assign rd_ok   = rd_enable && !arm && (state == S_DONE) &&
                   ({{(PW+1-AW){1'b0}}, rd_addr} < DEPTH_X);

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [W-1:0] ram_q;
      logic         v1;

      always_ff @(posedge clock) begin
        if (rd_ok) ram_q <= mem[rd_phys];
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          v1       <= 1'b0;
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else if (arm) begin
          v1       <= 1'b0;
          rd_valid <= 1'b0;
        end else begin
          v1       <= rd_ok;
          rd_valid <= v1;
          if (v1) rd_data <= ram_q;
        end
      end
    end else begin : g_noreg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= rd_ok;
          if (rd_ok) rd_data <= mem[rd_phys];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_bram_capture_buffer.sv
// Directed bench for bram_capture_buffer: three configurations share one stimulus
// bus (gated by sel); read results are checked against an expected queue.
module tb_bram_capture_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0, sample_valid = 1'b0, trigger = 1'b0, rd_enable = 1'b0;
  logic [15:0] sample_in = '0;
  logic [4:0]  rd_addr = '0;
  int          sel = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // expected entry: {dut id, cycle of rd_valid, data}
  logic [49:0] exp_q[$];

  logic        arm_v [3], sv_v [3], rde_v [3];
  logic [15:0] rdd [3];
  logic [2:0]  rv, bsy, trg, dn;
  logic [2:0]  st [3];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_gate
    assign arm_v[g] = arm && (sel == g);
    assign sv_v[g]  = sample_valid && (sel == g);
    assign rde_v[g] = rd_enable && (sel == g);
  end

  // A: depth 16, pre 4, registered output
  bram_capture_buffer #(.RAM_WIDTH(8), .NUM_CH(2), .RAM_DEPTH(16), .PRE_TRIG(4), .OUT_REG(1)) dut_a (
    .clock(clock), .reset(reset), .sample_valid(sv_v[0]), .sample_in(sample_in),
    .arm(arm_v[0]), .trigger(trigger), .rd_enable(rde_v[0]), .rd_addr(rd_addr[3:0]),
    .rd_data(rdd[0]), .rd_valid(rv[0]), .busy(bsy[0]), .triggered(trg[0]), .done(dn[0]),
    .dbg_state(st[0]));

  // B: depth 16, no pre-trigger history, unregistered output
  bram_capture_buffer #(.RAM_WIDTH(8), .NUM_CH(2), .RAM_DEPTH(16), .PRE_TRIG(0), .OUT_REG(0)) dut_b (
    .clock(clock), .reset(reset), .sample_valid(sv_v[1]), .sample_in(sample_in),
    .arm(arm_v[1]), .trigger(trigger), .rd_enable(rde_v[1]), .rd_addr(rd_addr[3:0]),
    .rd_data(rdd[1]), .rd_valid(rv[1]), .busy(bsy[1]), .triggered(trg[1]), .done(dn[1]),
    .dbg_state(st[1]));

  // C: non-power-of-two depth 17, pre 4, registered output
  bram_capture_buffer #(.RAM_WIDTH(8), .NUM_CH(2), .RAM_DEPTH(17), .PRE_TRIG(4), .OUT_REG(1)) dut_c (
    .clock(clock), .reset(reset), .sample_valid(sv_v[2]), .sample_in(sample_in),
    .arm(arm_v[2]), .trigger(trigger), .rd_enable(rde_v[2]), .rd_addr(rd_addr),
    .rd_data(rdd[2]), .rd_valid(rv[2]), .busy(bsy[2]), .triggered(trg[2]), .done(dn[2]),
    .dbg_state(st[2]));

  function automatic logic [15:0] word(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {b ^ 8'hFF, b};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic stream(input int first, input int last, input int trig_n, input bit gaps);
    for (int n = first; n <= last; n++) begin
      sample_valid = 1'b1;
      sample_in    = word(n);
      trigger      = (n == trig_n);
      tick();
      sample_valid = 1'b0;
      trigger      = 1'b0;
      if (gaps && (n % 2 == 1)) tick();
    end
  endtask

  task automatic rd(input int addr, input logic [15:0] d);
    int lat;
    lat = (sel == 1) ? 1 : 2;
    rd_enable = 1'b1;
    rd_addr   = 5'(addr);
    exp_q.push_back({2'(sel), 32'(cyc + lat), d});
    tick();
    rd_enable = 1'b0;
  endtask

  task automatic rd_drop(input int addr);
    rd_enable = 1'b1;
    rd_addr   = 5'(addr);
    tick();
    rd_enable = 1'b0;
  endtask

  task automatic quiet(input int n, input logic [15:0] hold, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      check({name, "_no_valid"}, 32'(rv[sel]), 32'd0);
      check({name, "_hold"}, 32'(rdd[sel]), 32'(hold));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every rd_valid pulse must match the head of the expected queue.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (rv[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected dut=%0d data=%h cyc=%0d required no rd_valid", k, rdd[k], cyc);
        end else begin
          logic [49:0] e, got;
          e   = exp_q.pop_front();
          got = {2'(k), 32'(cyc), rdd[k]};
          checks++;
          if (got !== e) begin
            errors++;
            $display("FAIL rd_result got dut=%0d cyc=%0d data=%h required dut=%0d cyc=%0d data=%h",
                     k, cyc, rdd[k], e[49:48], e[47:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d required finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_state", 32'(st[k]), 32'd0);
      check("rst_busy", 32'(bsy[k]), 32'd0);
      check("rst_trig", 32'(trg[k]), 32'd0);
      check("rst_done", 32'(dn[k]), 32'd0);
      check("rst_rd_data", 32'(rdd[k]), 32'd0);
    end

    // 1: basic capture, trigger at n=10
    sel = 0;
    do_arm();
    check("t1_arm_state", 32'(st[0]), 32'd1);
    check("t1_arm_busy", 32'(bsy[0]), 32'd1);
    stream(0, 9, -1, 1'b0);
    check("t1_pre_trig", 32'(trg[0]), 32'd0);
    check("t1_wait_state", 32'(st[0]), 32'd2);
    stream(10, 20, 10, 1'b0);
    check("t1_trig", 32'(trg[0]), 32'd1);
    check("t1_not_done", 32'(dn[0]), 32'd0);
    stream(21, 21, -1, 1'b0);
    check("t1_done", 32'(dn[0]), 32'd1);
    check("t1_idle_busy", 32'(bsy[0]), 32'd0);
    for (int i = 0; i < 16; i++) rd(i, word(6 + i));
    rd(4, 16'hF50A);
    drain();

    // 2: trigger in FILL ignored, real trigger at n=7
    do_arm();
    stream(0, 2, 2, 1'b0);
    check("t2_fill_ignores_trig", 32'(trg[0]), 32'd0);
    stream(3, 17, 7, 1'b0);
    check("t2_not_done", 32'(dn[0]), 32'd0);
    stream(18, 18, -1, 1'b0);
    check("t2_done", 32'(dn[0]), 32'd1);
    rd(0, word(3));
    rd(4, word(7));
    rd(15, word(18));
    drain();

    // 3: wrapped capture, trigger at n=40
    do_arm();
    stream(0, 39, -1, 1'b0);
    check("t3_before_trig", 32'(trg[0]), 32'd0);
    stream(40, 40, 40, 1'b0);
    check("t3_trig_rise", 32'(trg[0]), 32'd1);
    stream(41, 51, -1, 1'b0);
    check("t3_done", 32'(dn[0]), 32'd1);
    rd(0, word(36));
    rd(5, word(41));
    rd(15, word(51));
    drain();

    // 4: no pre-trigger history, gapped samples, 1-cycle latency
    sel = 1;
    do_arm();
    check("t4_arm_state", 32'(st[1]), 32'd2);
    check("t4_arm_busy", 32'(bsy[1]), 32'd1);
    stream(0, 0, 0, 1'b1);
    check("t4_trig", 32'(trg[1]), 32'd1);
    check("t4_post_state", 32'(st[1]), 32'd3);
    stream(1, 14, -1, 1'b1);
    check("t4_not_done", 32'(dn[1]), 32'd0);
    stream(15, 15, -1, 1'b1);
    check("t4_done", 32'(dn[1]), 32'd1);
    rd(0, word(0));
    rd(7, word(7));
    rd(15, word(15));
    drain();

    // 5: dropped reads outside DONE and out of range; re-arm from DONE
    sel = 2;
    rd_drop(0);
    quiet(3, 16'h0000, "t5_idle");
    do_arm();
    stream(0, 9, 6, 1'b0);
    check("t5_post_state", 32'(st[2]), 32'd3);
    rd_drop(16);
    quiet(3, 16'h0000, "t5_post");
    stream(10, 18, -1, 1'b0);
    check("t5_done", 32'(dn[2]), 32'd1);
    rd(16, word(18));
    rd(0, word(2));
    drain();
    rd_drop(17);
    quiet(3, word(2), "t5_range");
    do_arm();
    check("t5_rearm_done", 32'(dn[2]), 32'd0);
    check("t5_rearm_busy", 32'(bsy[2]), 32'd1);

    // 6: asynchronous reset mid-POST, then a clean capture
    sel = 0;
    do_arm();
    stream(0, 7, 5, 1'b0);
    check("t6_in_post", 32'(st[0]), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_busy", 32'(bsy[0]), 32'd0);
    check("t6_rst_trig", 32'(trg[0]), 32'd0);
    check("t6_rst_done", 32'(dn[0]), 32'd0);
    check("t6_rst_valid", 32'(rv[0]), 32'd0);
    check("t6_rst_state", 32'(st[0]), 32'd0);
    #1 reset = 1'b0;
    tick();
    check("t6_stay_idle", 32'(st[0]), 32'd0);
    do_arm();
    stream(100, 121, 110, 1'b0);
    check("t6_done", 32'(dn[0]), 32'd1);
    rd(0, word(106));
    rd(15, word(121));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_capture_buffer.md
Name: bram_capture_buffer

Overview:
Multi-channel, trigger-based sample capture memory built on a single inferred block RAM. It packs NUM_CH parallel samples into one RAM word. After arming, it records a pre-trigger history circularly, then a post-trigger window, then freezes. The frozen contents are read back in chronological order. It sits after the channel/filter datapath and feeds debug or BER readout logic.

Parameters:
RAM_WIDTH, 8, bits per channel sample
NUM_CH, 2, channels packed per RAM word (word width = NUM_CH*RAM_WIDTH, channel 0 in LSBs)
RAM_DEPTH, 1024, entries; any value >= 2
PRE_TRIG, 256, samples retained before trigger; legal range 0..RAM_DEPTH-1
OUT_REG, 1, 1 = registered output (2-cycle read latency); 0 = 1-cycle read latency

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears control state only, memory contents untouched
sample_valid  in  1  qualifies sample_in
sample_in  in  NUM_CH*RAM_WIDTH  packed channel samples
arm  in  1  single-cycle pulse; starts or restarts a capture from any state
trigger  in  1  trigger event, sampled only together with sample_valid
rd_enable  in  1  read request; honoured only in DONE
rd_addr  in  clogb2(RAM_DEPTH-1)  logical index, 0 = oldest captured sample
rd_data  out  NUM_CH*RAM_WIDTH  read data
rd_valid  out  1  rd_data valid pulse
busy  out  1  high in FILL, WAIT_TRIG, POST
triggered  out  1  high in POST and DONE
done  out  1  high in DONE

Behaviour:
- Reset (async): state=IDLE, wr_ptr=0, counters=0, rd_data=0, rd_valid=0, busy/triggered/done=0, read pipeline flushed.
- States: IDLE, FILL, WAIT_TRIG, POST, DONE.
- arm, any state: wr_ptr<=0, fill_cnt<=0, post_cnt<=0, done<=0, read pipeline cleared. Next state is FILL if PRE_TRIG>0, else WAIT_TRIG. Any sample_valid in the arm cycle is ignored.
- IDLE: no writes; trigger and rd_enable ignored.
- FILL: each sample_valid writes sample_in at wr_ptr, then wr_ptr increments. When wr_ptr==RAM_DEPTH-1, wr_ptr wraps to 0. fill_cnt increments; on the write where fill_cnt reaches PRE_TRIG, go to WAIT_TRIG. trigger is ignored in FILL.
- WAIT_TRIG: each sample_valid writes circularly. If trigger and sample_valid are both high in the same cycle:
  - that sample is the trigger sample; trig_ptr<=wr_ptr;
  - post_cnt<=1;
  - start_ptr<=(trig_ptr-PRE_TRIG) mod RAM_DEPTH, using explicit compare/add (no power-of-2 assumption);
  - go to POST.
  - If RAM_DEPTH-PRE_TRIG==1, go directly to DONE instead.
- POST: each sample_valid writes circularly and increments post_cnt. When post_cnt reaches RAM_DEPTH-PRE_TRIG (trigger sample included), go to DONE on that write. trigger is ignored in POST.
- DONE: no writes; sample_valid and trigger ignored.
- Read, DONE only:
  - Physical address = (start_ptr+rd_addr) mod RAM_DEPTH.
  - rd_addr >= RAM_DEPTH: request dropped, no rd_valid.
  - rd_data/rd_valid appear 1 cycle after rd_enable (OUT_REG=0) or 2 cycles after (OUT_REG=1). Back-to-back reads give one result per cycle.
  - rd_valid is a single-cycle pulse per accepted request.
  - rd_data holds its last value when not reading (no-change).
  - rd_enable outside DONE is dropped.
- Writes and reads are mutually exclusive by state, so no read-during-write hazard exists. The RAM is inferred as simple dual-port: write port driven by wr_ptr, read port by the computed address.
- Reset mid-capture: capture is aborted and state returns to IDLE. Captured data is not readable until a new capture completes.
- Width rules: pointers and counters are clogb2(RAM_DEPTH) bits. The wrap comparison is against RAM_DEPTH-1, never implicit overflow.

Test Plan:
1. RAM_DEPTH=16, PRE_TRIG=4, NUM_CH=2, RAM_WIDTH=8, OUT_REG=1. Arm; stream ch0=n, ch1=n^8'hFF for n=0,1,..; trigger with n=10. Expect done after the write of n=21. Reads of rd_addr 0..15 return ch0=6..21. rd_addr 4 returns {8'hF5,8'h0A}. rd_valid arrives exactly 2 cycles after each rd_enable.
2. Same config; trigger pulsed with n=2 (in FILL, ignored), then with n=7. Expect rd_addr 0 -> 3, rd_addr 4 -> 7, rd_addr 15 -> 18.
3. Wrap: trigger with n=40. Expect rd_addr 0 -> 36, rd_addr 15 -> 51. triggered rises the cycle after the n=40 write.
4. PRE_TRIG=0, OUT_REG=0. Arm, then trigger on the first valid (n=0); sample_valid gaps inserted. Expect done after 16 valids; rd_addr 0 -> 0; 1-cycle read latency.
5. rd_enable in IDLE/POST and rd_addr=16 with RAM_DEPTH=17 not in DONE: no rd_valid, rd_data unchanged. Re-arm from DONE: done drops the next cycle and busy rises.
6. Assert reset asynchronously mid-POST. Expect busy/triggered/done/rd_valid=0 before the next clock edge, and state IDLE. A following capture reads correct data.
